// File: rtl/jtag_debug_cmd_bridge.sv
// ----------------------------------------------------------------------------
// jtag_debug_cmd_bridge
//
// Sysclk-side receiver for the Nios II JTAG debug module. The virtual-JTAG
// update strobes (vs_uir, vs_udr) are brought into clk through flop chains.
// Their rising edges latch the IR and the scanned data register. Each captured
// command is offered on a valid/ready handshake. A one-cycle take_action or
// take_no_action strobe, one-hot by IR, fires when the command is captured.
//
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous active-low reset
//   ir_in          in   [IR_W]    IR from the TCK domain; stable around vs_uir
//   sr             in   [DATA_W]  data register from the TCK domain
//   vs_uir         in   update-IR level (asynchronous)
//   vs_udr         in   update-DR level (asynchronous)
//   cmd_ready      in   consumer accepts the pending command
//   jdo            out  [DATA_W]  captured sr
//   cmd_ir         out  [IR_W]    IR belonging to the captured command
//   cmd_valid      out  a command is pending
//   take_action    out  [2**IR_W] one-cycle strobe, jdo[ACTION_BIT]=1
//   take_no_action out  [2**IR_W] one-cycle strobe, jdo[ACTION_BIT]=0
//   overrun        out  sticky: an update-DR arrived while a command was pending
//   clr_overrun    in   synchronous clear of overrun (and of overrun_cnt)
//   overrun_cnt    out  [8] saturating overrun event count. This port exists
//                       only when JTAG_DEBUG_CMD_OVERRUN_CNT_EN is defined.
//
// Optional feature macro: JTAG_DEBUG_CMD_OVERRUN_CNT_EN
// SYNC_STAGES must lie in 2..4.
// ----------------------------------------------------------------------------
module jtag_debug_cmd_bridge #(
    parameter int DATA_W      = 38,
    parameter int IR_W        = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ACTION_BIT  = 34
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [IR_W-1:0]      ir_in,
    input  logic [DATA_W-1:0]    sr,
    input  logic                 vs_uir,
    input  logic                 vs_udr,
    input  logic                 cmd_ready,
    output logic [DATA_W-1:0]    jdo,
    output logic [IR_W-1:0]      cmd_ir,
    output logic                 cmd_valid,
    output logic [(1<<IR_W)-1:0] take_action,
    output logic [(1<<IR_W)-1:0] take_no_action,
    output logic                 overrun,
    input  logic                 clr_overrun
`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
    ,
    output logic [7:0]           overrun_cnt
`endif
);

    localparam int NCH = 1 << IR_W;

    typedef enum logic {IDLE, PEND} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] uir_sync_q, udr_sync_q;
    logic [SYNC_STAGES-1:0] prime_q;
    logic                   uir_last_q, udr_last_q;
    logic                   uir_p, udr_p;
    logic [IR_W-1:0]        ir_latched_q;
    logic [DATA_W-1:0]      jdo_q;
    logic [IR_W-1:0]        cmd_ir_q;
    logic                   strobe_q;
    logic                   overrun_q;
    logic                   capture;
    logic                   overrun_evt;
    logic [NCH-1:0]         ch_sel;

    // prime_q fills with ones at the same rate as the synchroniser chains.
    // The edge flops are held high until the chains carry real samples. A
    // strobe that is already high at reset release is therefore seen as an
    // old level and does not produce a pulse.
    // NOTE: sequential state uses non-blocking (<=) so that every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q <= '0;
            udr_sync_q <= '0;
            prime_q    <= '0;
            uir_last_q <= 1'b0;
            udr_last_q <= 1'b0;
        end else begin
            uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
            prime_q    <= {prime_q[SYNC_STAGES-2:0], 1'b1};
            uir_last_q <= prime_q[SYNC_STAGES-1] ? uir_sync_q[SYNC_STAGES-1] : 1'b1;
            udr_last_q <= prime_q[SYNC_STAGES-1] ? udr_sync_q[SYNC_STAGES-1] : 1'b1;
        end
    end

    assign uir_p = prime_q[SYNC_STAGES-1] & uir_sync_q[SYNC_STAGES-1] & ~uir_last_q;
    assign udr_p = prime_q[SYNC_STAGES-1] & udr_sync_q[SYNC_STAGES-1] & ~udr_last_q;

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic. In PEND, an update-DR that arrives together with
    // cmd_ready replaces the accepted command. Without cmd_ready it is an
    // overrun, and the new data is dropped.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        overrun_evt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (udr_p) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (udr_p) begin
                    if (cmd_ready) capture     = 1'b1;
                    else           overrun_evt = 1'b1;
                end else if (cmd_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath. A capture reads the ir_latched value from before this edge,
    // so a coincident update-IR affects only later commands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_latched_q <= '0;
            jdo_q        <= '0;
            cmd_ir_q     <= '0;
            strobe_q     <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (uir_p) ir_latched_q <= ir_in;
            if (capture) begin
                jdo_q    <= sr;
                cmd_ir_q <= ir_latched_q;
            end
            strobe_q <= capture;
            // A new overrun wins over a simultaneous clear.
            if (overrun_evt)      overrun_q <= 1'b1;
            else if (clr_overrun) overrun_q <= 1'b0;
        end
    end

`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun_cnt_q <= 8'd0;
        end else if (overrun_evt) begin
            if (clr_overrun)                overrun_cnt_q <= 8'd1;
            else if (overrun_cnt_q != 8'hFF) overrun_cnt_q <= overrun_cnt_q + 8'd1;
        end else if (clr_overrun) begin
            overrun_cnt_q <= 8'd0;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign ch_sel         = NCH'(1) << cmd_ir_q;
    assign jdo            = jdo_q;
    assign cmd_ir         = cmd_ir_q;
    assign cmd_valid      = (state_q == PEND);
    assign overrun        = overrun_q;
    assign take_action    = (strobe_q &&  jdo_q[ACTION_BIT]) ? ch_sel : '0;
    assign take_no_action = (strobe_q && !jdo_q[ACTION_BIT]) ? ch_sel : '0;

endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// ----------------------------------------------------------------------------
// Self-checking bench for jtag_debug_cmd_bridge.
// Stimulus pushes each expected command into a queue when it is issued. A
// monitor on the falling edge pops an entry and compares it whenever a
// take_* strobe appears. Control checks (latency, cmd_valid, overrun) run
// inline in the stimulus process.
// ----------------------------------------------------------------------------
module tb_jtag_debug_cmd_bridge;

    localparam int DATA_W = 38;
    localparam int IR_W   = 2;
    localparam int NCH    = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IR_W-1:0]   ir;
        logic              act;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [IR_W-1:0]   ir_in;
    logic [DATA_W-1:0] sr;
    logic              vs_uir, vs_udr, cmd_ready, clr_overrun;
    logic [DATA_W-1:0] jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic              cmd_valid, overrun;
    logic [NCH-1:0]    take_action, take_no_action;
`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    jtag_debug_cmd_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .cmd_ready      (cmd_ready),
        .jdo            (jdo),
        .cmd_ir         (cmd_ir),
        .cmd_valid      (cmd_valid),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .overrun        (overrun),
        .clr_overrun    (clr_overrun)
`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
        ,
        .overrun_cnt    (overrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic [IR_W-1:0] ir);
        exp_t e;
        e.data = d;
        e.ir   = ir;
        e.act  = d[34];
        sb_q.push_back(e);
    endtask

    task automatic pulse_uir(input logic [IR_W-1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    task automatic pulse_udr(input logic [DATA_W-1:0] d);
        sr     = d;
        vs_udr = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    task automatic ack();
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("ack_clears_valid", 64'(cmd_valid), 64'd0);
    endtask

    // Scoreboard monitor: every strobe cycle must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if ((|take_action) || (|take_no_action)) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_strobe", 64'({take_action, take_no_action}), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_jdo", 64'(jdo), 64'(e.data));
                    check("sb_cmd_ir", 64'(cmd_ir), 64'(e.ir));
                    check("sb_take_action", 64'(take_action),
                          e.act ? 64'(1) << e.ir : 64'd0);
                    check("sb_take_no_action", 64'(take_no_action),
                          e.act ? 64'd0 : 64'(1) << e.ir);
                    check("sb_valid", 64'(cmd_valid), 64'd1);
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] d_a, d_b, d_c, d_d;
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b1;
        cmd_ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        check("rst_jdo", 64'(jdo), 64'd0);
        check("rst_cmd_ir", 64'(cmd_ir), 64'd0);
        check("rst_valid", 64'(cmd_valid), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_strobes", 64'({take_action, take_no_action}), 64'd0);

        // Release reset with vs_udr already high: nothing may be captured.
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("rel_high_valid", 64'(cmd_valid), 64'd0);
        end
        vs_udr = 1'b0;
        tick(5);
        check("rel_high_jdo", 64'(jdo), 64'd0);

        // Action command on IR 1, with an exact latency check (SYNC_STAGES+1).
        pulse_uir(2'd1);
        d_a = 38'h04_0000_1234;
        push(d_a, 2'd1);
        sr = d_a;
        vs_udr = 1'b1;
        tick(2);
        check("lat_early_jdo", 64'(jdo), 64'd0);
        tick(1);
        check("lat_jdo", 64'(jdo), 64'(d_a));
        check("lat_cmd_ir", 64'(cmd_ir), 64'd1);
        check("lat_valid", 64'(cmd_valid), 64'd1);
        vs_udr = 1'b0;
        tick(6);
        check("valid_held", 64'(cmd_valid), 64'd1);
        ack();

        // No-action command on IR 3.
        pulse_uir(2'd3);
        d_b = 38'h00_0000_5678;
        push(d_b, 2'd3);
        pulse_udr(d_b);
        check("noact_jdo", 64'(jdo), 64'(d_b));
        check("noact_valid", 64'(cmd_valid), 64'd1);
        ack();

        // Overrun: a second update-DR while pending, without cmd_ready.
        pulse_uir(2'd2);
        d_c = 38'h07_1111_2222;
        push(d_c, 2'd2);
        pulse_udr(d_c);
        pulse_udr(38'h02_3333_4444);
        check("ovr_jdo_hold", 64'(jdo), 64'(d_c));
        check("ovr_flag", 64'(overrun), 64'd1);
        check("ovr_valid", 64'(cmd_valid), 64'd1);
`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
        check("ovr_cnt_one", 64'(overrun_cnt), 64'd1);
`endif
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("ovr_clr", 64'(overrun), 64'd0);

        // update-DR coincident with cmd_ready in PEND: replace, no overrun.
        d_d = 38'h00_0000_ABCD;
        push(d_d, 2'd2);
        sr = d_d;
        vs_udr = 1'b1;
        tick(2);             // udr_p is high during this cycle
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("coinc_jdo", 64'(jdo), 64'(d_d));
        check("coinc_valid", 64'(cmd_valid), 64'd1);
        check("coinc_no_ovr", 64'(overrun), 64'd0);
        vs_udr = 1'b0;
        tick(4);
        ack();

        // cmd_ready while IDLE is ignored.
        cmd_ready = 1'b1;
        tick(3);
        cmd_ready = 1'b0;
        check("idle_ready_valid", 64'(cmd_valid), 64'd0);

        // Coincident update-IR and update-DR: the capture uses the old IR (2).
        ir_in = 2'd0;
        push(38'h04_5555_0001, 2'd2);
        sr = 38'h04_5555_0001;
        vs_uir = 1'b1;
        vs_udr = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        vs_udr = 1'b0;
        tick(4);
        check("same_cyc_ir", 64'(cmd_ir), 64'd2);
        ack();
        push(38'h00_5555_0002, 2'd0);
        pulse_udr(38'h00_5555_0002);
        check("same_cyc_next_ir", 64'(cmd_ir), 64'd0);

        // Reset while the command is still pending drops it.
        reset_n = 1'b0;
        tick(2);
        check("midrst_valid", 64'(cmd_valid), 64'd0);
        check("midrst_jdo", 64'(jdo), 64'd0);
        reset_n = 1'b1;
        tick(5);

`ifdef JTAG_DEBUG_CMD_OVERRUN_CNT_EN
        // 300 overruns saturate the counter at 255; the clear returns it to 0.
        pulse_uir(2'd1);
        push(38'h04_0000_0300, 2'd1);
        pulse_udr(38'h04_0000_0300);
        for (int i = 0; i < 300; i++) begin
            sr = 38'h0;
            vs_udr = 1'b1;
            tick(3);
            vs_udr = 1'b0;
            tick(3);
        end
        tick(3);
        check("cnt_sat", 64'(overrun_cnt), 64'd255);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("cnt_clr", 64'(overrun_cnt), 64'd0);
        ack();
`endif

        tick(5);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
